// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        ALU_ADDSUB = 2'b00,
        ALU_SHIFT  = 2'b01,
        ALU_AND    = 2'b10,
        ALU_OR     = 2'b11
    } aluOp_t;

    typedef struct packed {
        logic n;
        logic nz;
        logic c;
    } aluFlags_t;

    localparam logic DIR_ADD   = 1'b0;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_SUB   = 1'b1;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath: result and carry
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_operandA,
    input  logic [WIDTH-1:0] i_operandB,
    input  aluOp_t           i_op,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH-1:0] bOperand;
    logic [WIDTH:0]   sum;

    // Subtract as A + ~B + 1 so the carry-out doubles as a no-borrow flag
    assign bOperand = i_dir ? ~i_operandB : i_operandB;
    assign sum      = {1'b0, i_operandA} + {1'b0, bOperand} + {{WIDTH{1'b0}}, i_dir};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            ALU_ADDSUB: begin
                o_result = sum[WIDTH-1:0];
                o_carry  = sum[WIDTH];
            end
            ALU_SHIFT: begin
                if (i_dir == DIR_RIGHT) begin
                    o_result = {1'b0, i_operandA[WIDTH-1:1]};
                    o_carry  = i_operandA[0];
                end else begin
                    o_result = {i_operandA[WIDTH-2:0], 1'b0};
                    o_carry  = i_operandA[WIDTH-1];
                end
            end
            ALU_AND: o_result = i_operandA & i_operandB;
            ALU_OR:  o_result = i_operandA | i_operandB;
            default: begin
                o_result = '0;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered ALU stage with flag outputs and gated bus driver
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_nReset,
    input  logic [WIDTH-1:0] i_operandA,
    input  logic [WIDTH-1:0] i_operandB,
    input  logic [1:0]       i_ctrlAluOp,
    input  logic             i_ctrlAluSubShiftDir,
    input  logic             i_ctrlAluWr,
    input  logic             i_ctrlAluNOE,
    output logic [WIDTH-1:0] o_busData,
    output logic             o_busEn,
    output logic             o_aluFlagN,
    output logic             o_aluFlagNZ,
    output logic             o_aluFlagC
);

    logic [WIDTH-1:0] coreResult;
    logic             coreCarry;
    logic [WIDTH-1:0] rResult;
    aluFlags_t        rFlags;

    alu_core #(.WIDTH(WIDTH)) uCore (
        .i_operandA (i_operandA),
        .i_operandB (i_operandB),
        .i_op       (aluOp_t'(i_ctrlAluOp)),
        .i_dir      (i_ctrlAluSubShiftDir),
        .o_result   (coreResult),
        .o_carry    (coreCarry)
    );

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            rResult <= '0;
            rFlags  <= '0;
        end else if (i_ctrlAluWr) begin
            rResult   <= coreResult;
            rFlags.n  <= coreResult[WIDTH-1];
            rFlags.nz <= |coreResult;
            rFlags.c  <= coreCarry;
        end
    end

    // Bus is driven only from the register, never straight from the operands
    assign o_busEn     = ~i_ctrlAluNOE;
    assign o_busData   = rResult & {WIDTH{~i_ctrlAluNOE}};
    assign o_aluFlagN  = rFlags.n;
    assign o_aluFlagNZ = rFlags.nz;
    assign o_aluFlagC  = rFlags.c;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - scoreboard bench for alu_unit against an arithmetic reference model
module tb_alu_unit;

    logic       i_clk;
    logic       i_nReset;
    logic [7:0] i_operandA;
    logic [7:0] i_operandB;
    logic [1:0] i_ctrlAluOp;
    logic       i_ctrlAluSubShiftDir;
    logic       i_ctrlAluWr;
    logic       i_ctrlAluNOE;
    logic [7:0] o_busData;
    logic       o_busEn;
    logic       o_aluFlagN;
    logic       o_aluFlagNZ;
    logic       o_aluFlagC;

    alu_unit dut (
        .i_clk                (i_clk),
        .i_nReset             (i_nReset),
        .i_operandA           (i_operandA),
        .i_operandB           (i_operandB),
        .i_ctrlAluOp          (i_ctrlAluOp),
        .i_ctrlAluSubShiftDir (i_ctrlAluSubShiftDir),
        .i_ctrlAluWr          (i_ctrlAluWr),
        .i_ctrlAluNOE         (i_ctrlAluNOE),
        .o_busData            (o_busData),
        .o_busEn              (o_busEn),
        .o_aluFlagN           (o_aluFlagN),
        .o_aluFlagNZ          (o_aluFlagNZ),
        .o_aluFlagC           (o_aluFlagC)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected register contents after each accepted write: {result, N, NZ, C}
    logic [10:0] expQ[$];
    bit          done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [10:0] model(input int a, input int b, input int op, input bit dir);
        int r;
        bit c;
        r = 0;
        c = 1'b0;
        case (op)
            0: if (!dir) begin r = a + b; c = (r > 255); end
               else      begin r = a - b; c = (a >= b); end
            1: if (!dir) begin r = a * 2; c = (a >= 128); end
               else      begin r = a / 2; c = (a % 2 == 1); end
            2: r = a & b;
            default: r = a | b;
        endcase
        r = r & 255;
        return {r[7:0], r >= 128, r != 0, c};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic dir, input logic wr, input logic noe);
        @(negedge i_clk);
        i_operandA           = a;
        i_operandB           = b;
        i_ctrlAluOp          = op;
        i_ctrlAluSubShiftDir = dir;
        i_ctrlAluWr          = wr;
        i_ctrlAluNOE         = noe;
        if (wr) expQ.push_back(model(int'(a), int'(b), int'(op), dir));
    endtask

    // Stimulus
    initial begin
        i_nReset = 1'b1;
        i_operandA = 8'h00; i_operandB = 8'h00; i_ctrlAluOp = 2'b00;
        i_ctrlAluSubShiftDir = 1'b0; i_ctrlAluWr = 1'b0; i_ctrlAluNOE = 1'b0;
        #2 i_nReset = 1'b0;
        @(negedge i_clk);
        i_nReset = 1'b1;

        drive(8'h7F, 8'h01, 2'b00, 1'b0, 1'b1, 1'b0);
        drive(8'hFF, 8'h01, 2'b00, 1'b0, 1'b1, 1'b0);
        drive(8'h05, 8'h05, 2'b00, 1'b1, 1'b1, 1'b0);
        drive(8'h03, 8'h05, 2'b00, 1'b1, 1'b1, 1'b0);
        drive(8'h81, 8'($urandom), 2'b01, 1'b1, 1'b1, 1'b0);
        drive(8'h81, 8'($urandom), 2'b01, 1'b0, 1'b1, 1'b0);
        drive(8'hF0, 8'h3C, 2'b10, 1'b0, 1'b1, 1'b0);
        drive(8'hF0, 8'h3C, 2'b11, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b0);
        drive(8'h12, 8'h34, 2'b00, 1'b0, 1'b0, 1'b1);
        drive(8'h12, 8'h34, 2'b00, 1'b0, 1'b1, 1'b1);

        // Reset pulse between edges, then reset coinciding with a write
        @(negedge i_clk);
        i_ctrlAluWr = 1'b0;
        #3 i_nReset = 1'b0;
        #1 i_nReset = 1'b1;
        drive(8'h40, 8'h40, 2'b00, 1'b0, 1'b1, 1'b0);
        @(negedge i_clk);
        i_operandA = 8'h55; i_ctrlAluOp = 2'b11; i_ctrlAluWr = 1'b1;
        #3 i_nReset = 1'b0;
        @(negedge i_clk);
        i_ctrlAluWr = 1'b0;
        i_nReset = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 60; i++)
            drive(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
        drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Monitor: tracks the architectural register state from the scoreboard and
    // compares every visible output after each clock edge and reset event
    initial begin
        logic [10:0] held;
        logic [11:0] act;
        logic [11:0] exp;
        bit          prevClk;
        bit          prevRst;
        bit          wasWr;
        string       tag;
        held    = '0;
        prevClk = 1'b0;
        prevRst = 1'b1;
        while (!done) begin
            @(posedge i_clk or negedge i_clk or negedge i_nReset);
            if (prevRst && !i_nReset) begin
                held = '0;
                tag  = "reset_async";
                #1;
            end else if (i_clk && !prevClk) begin
                wasWr = i_ctrlAluWr && i_nReset;
                tag   = wasWr ? "after_write" : "hold";
                #1;
                if (!i_nReset) begin
                    held = '0;
                    tag  = "reset_edge";
                end else if (wasWr) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_underflow: write seen with no expected entry");
                    end else begin
                        held = expQ.pop_front();
                    end
                end
            end else begin
                tag = "mid_cycle";
                #1;
            end
            prevClk = i_clk;
            prevRst = i_nReset;

            exp = {(i_ctrlAluNOE ? 8'h00 : held[10:3]), ~i_ctrlAluNOE, held[2:0]};
            act = {o_busData, o_busEn, o_aluFlagN, o_aluFlagNZ, o_aluFlagC};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s @%0t: bus=%h en=%b N=%b NZ=%b C=%b, required bus=%h en=%b N=%b NZ=%b C=%b",
                         tag, $time, act[11:4], act[3], act[2], act[1], act[0],
                         exp[11:4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
